// File: rtl/pipe_acc_core.sv
// Three-stage (IF/ID/EX) pipelined accumulator processor with a host load port,
// start/halt control, branch flushing, store-to-load forwarding and a retire counter.
module pipe_acc_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [ADDR_W+3:0] prog_wdata,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              carry,
    output logic              zero,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_cnt
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] OP_LDA = 4'd1, OP_STA = 4'd2, OP_ADD = 4'd3, OP_SUB = 4'd4,
                           OP_LDI = 4'd5, OP_JMP = 4'd6, OP_JZ  = 4'd7, OP_HLT = 4'd8;

    logic [ADDR_W+3:0] imem [DEPTH];
    logic [DATA_W-1:0] dmem [DEPTH];

    // vld_pipe[1] qualifies IF/ID, vld_pipe[2] qualifies ID/EX
    logic [2:1]        vld_pipe;
    logic [ADDR_W+3:0] if_id_ir;
    logic [ADDR_W-1:0] if_id_pc;
    logic [3:0]        id_ex_op;
    logic [ADDR_W-1:0] id_ex_arg;
    logic [ADDR_W-1:0] id_ex_pc;
    logic [DATA_W-1:0] id_ex_opd;

    logic [3:0]        id_op;
    logic [ADDR_W-1:0] id_arg;
    logic [DATA_W-1:0] id_opd;
    logic              ex_v, ex_sta, ex_taken, ex_hlt;
    logic [DATA_W:0]   sum, diff;

    assign id_op  = if_id_ir[ADDR_W+3:ADDR_W];
    assign id_arg = if_id_ir[ADDR_W-1:0];

    assign ex_v     = vld_pipe[2] && !halted;
    assign ex_sta   = ex_v && (id_ex_op == OP_STA);
    assign ex_taken = ex_v && ((id_ex_op == OP_JMP) || ((id_ex_op == OP_JZ) && zero));
    assign ex_hlt   = ex_v && (id_ex_op == OP_HLT);

    // A store in EX has not reached dmem yet, so a same-address read in ID takes acc.
    assign id_opd = (ex_sta && (id_ex_arg == id_arg)) ? acc : dmem[id_arg];

    assign sum  = {1'b0, acc} + {1'b0, id_ex_opd};
    assign diff = {1'b0, acc} - {1'b0, id_ex_opd};

    assign data_rdata = dmem[data_addr];
    assign zero       = (acc == '0);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            pc        <= '0;
            carry     <= 1'b0;
            halted    <= 1'b1;
            instr_cnt <= '0;
            vld_pipe  <= '0;
            if_id_ir  <= '0;
            if_id_pc  <= '0;
            id_ex_op  <= '0;
            id_ex_arg <= '0;
            id_ex_pc  <= '0;
            id_ex_opd <= '0;
        end else if (halted) begin
            if (start) begin
                halted    <= 1'b0;
                pc        <= '0;
                vld_pipe  <= '0;
                instr_cnt <= '0;
                carry     <= 1'b0;
            end
        end else begin
            pc        <= pc + 1'b1;
            if_id_ir  <= imem[pc];
            if_id_pc  <= pc;
            id_ex_op  <= id_op;
            id_ex_arg <= id_arg;
            id_ex_pc  <= if_id_pc;
            id_ex_opd <= id_opd;
            vld_pipe  <= {vld_pipe[1], 1'b1};
            if (ex_v) begin
                instr_cnt <= instr_cnt + 1'b1;
                case (id_ex_op)
                    OP_LDA:  acc <= id_ex_opd;
                    OP_ADD:  {carry, acc} <= sum;
                    OP_SUB:  {carry, acc} <= diff;
                    OP_LDI:  acc <= DATA_W'(id_ex_arg);
                    default: ;
                endcase
            end
            if (ex_taken) begin
                pc       <= id_ex_arg;
                vld_pipe <= '0;
            end
            if (ex_hlt) begin
                halted   <= 1'b1;
                pc       <= id_ex_pc + 1'b1;
                vld_pipe <= '0;
            end
        end
    end

    // Host writes only land while halted, so they never collide with an executing STA.
    always_ff @(posedge clk1) begin
        if (halted && prog_we)
            imem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk1) begin
        if (halted && data_we)
            dmem[data_addr] <= data_wdata;
        else if (ex_sta)
            dmem[id_ex_arg] <= acc;
    end
endmodule

// File: tb/tb_pipe_acc_core.sv
// Self-checking bench for pipe_acc_core: programs are loaded through the host port,
// expected end states are queued at launch and compared when the core halts.
module tb_pipe_acc_core;
    localparam int DW = 16, AW = 5, CW = 16;
    localparam logic [3:0] NOP = 4'd0, LDA = 4'd1, STA = 4'd2, ADD = 4'd3, SUB = 4'd4,
                           LDI = 4'd5, JMP = 4'd6, JZ  = 4'd7, HLT = 4'd8;

    logic          clk1 = 1'b0, rst = 1'b1, start = 1'b0, prog_we = 1'b0, data_we = 1'b0;
    logic [AW-1:0] prog_addr = '0, data_addr = '0;
    logic [AW+3:0] prog_wdata = '0;
    logic [DW-1:0] data_wdata = '0;
    logic [DW-1:0] data_rdata, acc;
    logic [AW-1:0] pc;
    logic          carry, zero, halted;
    logic [CW-1:0] instr_cnt;

    typedef struct {
        string         tag;
        logic [DW-1:0] acc;
        logic [AW-1:0] pc;
        logic          carry;
        logic          zero;
        logic [CW-1:0] cnt;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_pass = 0;
    logic mon_en = 1'b0, bad_seen = 1'b0;

    pipe_acc_core #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk1(clk1), .rst(rst), .start(start),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .acc(acc), .pc(pc), .carry(carry), .zero(zero),
        .halted(halted), .instr_cnt(instr_cnt)
    );

    always #5 clk1 = ~clk1;

    always @(negedge clk1)
        if (mon_en && (acc == 16'd1 || acc == 16'd2)) bad_seen <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [AW+3:0] ins(input logic [3:0] op, input logic [AW-1:0] a);
        return {op, a};
    endfunction

    task automatic wr_i(input logic [AW-1:0] a, input logic [AW+3:0] w);
        prog_we = 1'b1; prog_addr = a; prog_wdata = w;
        @(negedge clk1);
        prog_we = 1'b0;
    endtask

    task automatic wr_d(input logic [AW-1:0] a, input logic [DW-1:0] w);
        data_we = 1'b1; data_addr = a; data_wdata = w;
        @(negedge clk1);
        data_we = 1'b0;
    endtask

    task automatic rd_d(input logic [AW-1:0] a, output logic [DW-1:0] d);
        data_addr = a;
        #1 d = data_rdata;
    endtask

    task automatic push(input string tag, input logic [DW-1:0] a, input logic [AW-1:0] p,
                        input logic c, input logic z, input logic [CW-1:0] n);
        exp_t e;
        e.tag = tag; e.acc = a; e.pc = p; e.carry = c; e.zero = z; e.cnt = n;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
    endtask

    task automatic finish_run();
        exp_t e;
        int   n;
        n = 0;
        while (!halted && n < 300) begin
            @(negedge clk1);
            n++;
        end
        e = sb.pop_front();
        chk({e.tag, "_halted"}, {31'b0, halted}, 32'd1);
        chk({e.tag, "_acc"},    {16'b0, acc},    {16'b0, e.acc});
        chk({e.tag, "_pc"},     {27'b0, pc},     {27'b0, e.pc});
        chk({e.tag, "_carry"},  {31'b0, carry},  {31'b0, e.carry});
        chk({e.tag, "_zero"},   {31'b0, zero},   {31'b0, e.zero});
        chk({e.tag, "_cnt"},    {16'b0, instr_cnt}, {16'b0, e.cnt});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_halted"}, {31'b0, halted}, 32'd1);
        chk({tag, "_acc"},    {16'b0, acc},    32'd0);
        chk({tag, "_pc"},     {27'b0, pc},     32'd0);
        chk({tag, "_zero"},   {31'b0, zero},   32'd1);
        chk({tag, "_carry"},  {31'b0, carry},  32'd0);
        chk({tag, "_cnt"},    {16'b0, instr_cnt}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] d;

        repeat (2) @(negedge clk1);
        chk_reset_state("por");
        rst = 1'b0;
        @(negedge clk1);

        // Reset mid-run: endless ADD loop, then async reset between edges
        wr_d(5'd3, 16'h0007);
        wr_i(5'd0, ins(ADD, 5'd3));
        wr_i(5'd1, ins(JMP, 5'd0));
        pulse_start();
        repeat (20) @(negedge clk1);
        chk("running", {31'b0, halted}, 32'd0);
        #2 rst = 1'b1;
        #1 chk_reset_state("midrst");
        @(negedge clk1);
        rst = 1'b0;
        rd_d(5'd3, d);
        chk("midrst_d3", {16'b0, d}, 32'h0007);

        // Basic program with latency check
        wr_i(5'd0, ins(LDI, 5'd5));
        wr_i(5'd1, ins(ADD, 5'd3));
        wr_i(5'd2, ins(STA, 5'd10));
        wr_i(5'd3, ins(HLT, 5'd0));
        push("basic", 16'h000C, 5'd4, 1'b0, 1'b0, 16'd4);
        pulse_start();
        chk("basic_pc0", {27'b0, pc}, 32'd0);
        @(negedge clk1);
        chk("lat_e1", {16'b0, acc}, 32'd0);
        @(negedge clk1);
        chk("lat_e2", {16'b0, acc}, 32'd0);
        @(negedge clk1);
        chk("lat_e3", {16'b0, acc}, 32'd5);
        finish_run();
        rd_d(5'd10, d);
        chk("basic_d10", {16'b0, d}, 32'h000C);

        // Overflow then borrow
        wr_d(5'd0, 16'hFFFF);
        wr_d(5'd1, 16'h0001);
        wr_i(5'd0, ins(LDA, 5'd0));
        wr_i(5'd1, ins(ADD, 5'd1));
        wr_i(5'd2, ins(HLT, 5'd0));
        push("ovf", 16'h0000, 5'd3, 1'b1, 1'b1, 16'd3);
        pulse_start();
        finish_run();
        wr_i(5'd0, ins(LDI, 5'd0));
        wr_i(5'd1, ins(SUB, 5'd1));
        push("borrow", 16'hFFFF, 5'd3, 1'b1, 1'b0, 16'd3);
        pulse_start();
        finish_run();

        // Branch flush: wrong-path LDI 1 / LDI 2 must never retire
        wr_i(5'd0, ins(LDI, 5'd0));
        wr_i(5'd1, ins(JZ,  5'd5));
        wr_i(5'd2, ins(LDI, 5'd1));
        wr_i(5'd3, ins(LDI, 5'd2));
        wr_i(5'd4, ins(NOP, 5'd0));
        wr_i(5'd5, ins(LDI, 5'd7));
        wr_i(5'd6, ins(HLT, 5'd0));
        push("branch", 16'h0007, 5'd7, 1'b0, 1'b0, 16'd4);
        mon_en = 1'b1;
        pulse_start();
        finish_run();
        mon_en = 1'b0;
        chk("branch_no_wrong_path", {31'b0, bad_seen}, 32'd0);

        // Store-to-load forwarding
        wr_d(5'd4, 16'h0000);
        wr_i(5'd0, ins(LDI, 5'd9));
        wr_i(5'd1, ins(STA, 5'd4));
        wr_i(5'd2, ins(LDA, 5'd4));
        wr_i(5'd3, ins(ADD, 5'd4));
        wr_i(5'd4, ins(HLT, 5'd0));
        push("fwd", 16'h0012, 5'd5, 1'b0, 1'b0, 16'd5);
        pulse_start();
        finish_run();
        rd_d(5'd4, d);
        chk("fwd_d4", {16'b0, d}, 32'h0009);

        // Guarded host port: writes and start while running are ignored
        wr_d(5'd20, 16'h1111);
        wr_i(5'd0, ins(LDI, 5'd1));
        for (int i = 1; i < 10; i++) wr_i(i[AW-1:0], ins(NOP, 5'd0));
        wr_i(5'd10, ins(LDI, 5'd3));
        wr_i(5'd11, ins(HLT, 5'd0));
        push("guard", 16'h0003, 5'd12, 1'b0, 1'b0, 16'd12);
        pulse_start();
        wr_i(5'd10, ins(LDI, 5'd9));
        wr_d(5'd20, 16'hBEEF);
        pulse_start();
        chk("guard_start_pc", {27'b0, pc}, 32'd3);
        chk("guard_start_cnt", {16'b0, instr_cnt}, 32'd1);
        finish_run();
        rd_d(5'd20, d);
        chk("guard_d20", {16'b0, d}, 32'h1111);

        push("rerun", 16'h0003, 5'd12, 1'b0, 1'b0, 16'd12);
        pulse_start();
        chk("rerun_cnt0", {16'b0, instr_cnt}, 32'd0);
        chk("rerun_pc0", {27'b0, pc}, 32'd0);
        finish_run();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
